// File: rtl/mips32i_fetch_unit_if.sv
// Fetch-stage bus bundle: redirect input, instruction-memory handshake and decode-side queue head.
// Optional macro FETCH_ALIGN_CHK_EN adds the sticky if_misalign flag.
interface mips32i_fetch_unit_if;
   logic [31:0] next_PC;
   logic        redirect;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        if_valid;
   logic [31:0] if_instr;
   logic [31:0] if_PC_plus4;
   logic        if_ready;
   logic [31:0] fetch_PC;
`ifdef FETCH_ALIGN_CHK_EN
   logic        if_misalign;
`endif

   modport master (
      input  next_PC,
      input  redirect,
      input  imem_ack,
      input  imem_rdata,
      input  if_ready,
      output imem_req,
      output imem_addr,
      output if_valid,
      output if_instr,
      output if_PC_plus4,
      output fetch_PC
`ifdef FETCH_ALIGN_CHK_EN
      , output if_misalign
`endif
   );

   modport slave (
      output next_PC,
      output redirect,
      output imem_ack,
      output imem_rdata,
      output if_ready,
      input  imem_req,
      input  imem_addr,
      input  if_valid,
      input  if_instr,
      input  if_PC_plus4,
      input  fetch_PC
`ifdef FETCH_ALIGN_CHK_EN
      , input if_misalign
`endif
   );
endinterface

// File: rtl/mips32i_fetch_unit.sv
// MIPS32 instruction-fetch stage: fetch PC, single-outstanding imem reads, small FIFO toward decode.
// Optional macro FETCH_ALIGN_CHK_EN: misaligned redirect targets raise if_misalign and halt fetch.
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_FETCH   | normal sequential fetch, request issued while a slot is free
// ST_DISCARD | stale request in flight after redirect; its data is dropped
// ST_HALT    | misaligned redirect seen; no fetch until reset (option only)
module mips32i_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          QDEPTH   = 2
) (
   input logic                  clk,
   input logic                  rst,
   mips32i_fetch_unit_if.master fetch_if
);
   localparam int PW = $clog2(QDEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] QDEPTH_C = CW'(QDEPTH);

   typedef enum logic [1:0] {
      ST_FETCH   = 2'd0,
      ST_DISCARD = 2'd1
`ifdef FETCH_ALIGN_CHK_EN
      , ST_HALT  = 2'd2
`endif
   } state_t;

   state_t        state_q, state_d;
   logic [31:0]   fetch_pc_q, fetch_pc_d;
   logic [31:0]   pend_pc_q, pend_pc_d;
   logic          outst_q, outst_d;
   logic [CW-1:0] count_q, count_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [31:0]   instr_q [QDEPTH];
   logic [31:0]   pc4_q   [QDEPTH];

   logic          req;
   logic          push;
   logic          pop;
   logic          flush;
   logic          misalign_hit;
   logic [31:0]   redir_target;

   assign redir_target = fetch_if.next_PC & 32'hFFFF_FFFC;

`ifdef FETCH_ALIGN_CHK_EN
   logic misalign_q, misalign_d;
   assign misalign_hit = fetch_if.redirect && (fetch_if.next_PC[1:0] != 2'b00);
`else
   assign misalign_hit = 1'b0;
`endif

   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      pend_pc_d  = pend_pc_q;
      outst_d    = outst_q;
      req        = 1'b0;
      push       = 1'b0;
      flush      = 1'b0;
`ifdef FETCH_ALIGN_CHK_EN
      misalign_d = misalign_q;
`endif
      case (state_q)
         ST_FETCH: begin
            // an issued request is held until ack even if the queue filled meanwhile
            req = outst_q || (count_q < QDEPTH_C);
            if (fetch_if.redirect) begin
               flush = 1'b1;
               if (misalign_hit) begin
`ifdef FETCH_ALIGN_CHK_EN
                  state_d    = ST_HALT;
                  misalign_d = 1'b1;
`endif
                  outst_d = 1'b0;
               end else if (req && !fetch_if.imem_ack) begin
                  state_d   = ST_DISCARD;
                  pend_pc_d = redir_target;
                  outst_d   = 1'b1;
               end else begin
                  fetch_pc_d = redir_target;
                  outst_d    = 1'b0;
               end
            end else if (req && fetch_if.imem_ack) begin
               push       = 1'b1;
               fetch_pc_d = fetch_pc_q + 32'd4;
               outst_d    = 1'b0;
            end else begin
               outst_d = req;
            end
         end
         ST_DISCARD: begin
            req = 1'b1;
            if (fetch_if.redirect) begin
               flush = 1'b1;
               if (misalign_hit) begin
`ifdef FETCH_ALIGN_CHK_EN
                  state_d    = ST_HALT;
                  misalign_d = 1'b1;
`endif
                  outst_d = 1'b0;
               end else if (fetch_if.imem_ack) begin
                  state_d    = ST_FETCH;
                  fetch_pc_d = redir_target;
                  outst_d    = 1'b0;
               end else begin
                  pend_pc_d = redir_target;
               end
            end else if (fetch_if.imem_ack) begin
               state_d    = ST_FETCH;
               fetch_pc_d = pend_pc_q;
               outst_d    = 1'b0;
            end
         end
         default: begin
            req     = 1'b0;
            outst_d = 1'b0;
         end
      endcase
   end

   assign pop = (count_q != '0) && fetch_if.if_ready && !flush;

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (flush) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + PW'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
         count_d = count_q + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_FETCH;
         fetch_pc_q <= RESET_PC;
         pend_pc_q  <= RESET_PC;
         outst_q    <= 1'b0;
         count_q    <= '0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         pend_pc_q  <= pend_pc_d;
         outst_q    <= outst_d;
         count_q    <= count_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
      end
   end

   // queue payload needs no reset; count_q qualifies every entry
   always_ff @(posedge clk) begin
      if (push) begin
         instr_q[wr_ptr_q] <= fetch_if.imem_rdata;
         pc4_q[wr_ptr_q]   <= fetch_pc_q + 32'd4;
      end
   end

`ifdef FETCH_ALIGN_CHK_EN
   always_ff @(posedge clk) begin
      if (rst) misalign_q <= 1'b0;
      else     misalign_q <= misalign_d;
   end
   assign fetch_if.if_misalign = misalign_q;
`endif

   assign fetch_if.imem_req    = req && !rst;
   assign fetch_if.imem_addr   = fetch_pc_q;
   assign fetch_if.fetch_PC    = fetch_pc_q;
   assign fetch_if.if_valid    = (count_q != '0);
   assign fetch_if.if_instr    = instr_q[rd_ptr_q];
   assign fetch_if.if_PC_plus4 = pc4_q[rd_ptr_q];
endmodule

// File: tb/tb_mips32i_fetch_unit.sv
// Directed bench for mips32i_fetch_unit: sequential fetch, stall, redirect/discard, PC wrap, optional halt.
module tb_mips32i_fetch_unit;
   logic clk;
   logic rst;
   int   n_chk;
   int   n_err;

   logic auto_ack;
   logic man_ack;
   int   lat;
   int   wcnt;

`ifdef FETCH_ALIGN_CHK_EN
   localparam logic [31:0] R2_PC = 32'h0000_0400;
`else
   localparam logic [31:0] R2_PC = 32'h0000_0403;
`endif

   mips32i_fetch_unit_if fu ();
   mips32i_fetch_unit_if fu2 ();

   mips32i_fetch_unit #(.RESET_PC(32'h0000_0000), .QDEPTH(2)) dut (
      .clk(clk), .rst(rst), .fetch_if(fu)
   );

   mips32i_fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .QDEPTH(2)) dut_wrap (
      .clk(clk), .rst(rst), .fetch_if(fu2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // memory model: ack after lat cycles of held request, or manual ack
   assign fu.imem_ack   = auto_ack ? (fu.imem_req && (wcnt >= lat)) : man_ack;
   assign fu.imem_rdata = ~fu.imem_addr;
   always @(posedge clk) begin
      if (!fu.imem_req || fu.imem_ack) wcnt <= 0;
      else                             wcnt <= wcnt + 1;
   end

   assign fu2.imem_ack   = fu2.imem_req;
   assign fu2.imem_rdata = ~fu2.imem_addr;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      n_chk = 0;
      n_err = 0;
      rst = 1'b1;
      auto_ack = 1'b1;
      man_ack = 1'b0;
      lat = 0;
      fu.next_PC = 32'h0;
      fu.redirect = 1'b0;
      fu.if_ready = 1'b1;
      fu2.next_PC = 32'h0;
      fu2.redirect = 1'b0;
      fu2.if_ready = 1'b1;

      // reset values and zero-wait sequential fetch
      tick();
      tick();
      chk("rst_req", 32'(fu.imem_req), 32'h0);
      chk("rst_valid", 32'(fu.if_valid), 32'h0);
      chk("rst_fetch_pc", fu.fetch_PC, 32'h0);
      chk("rst_wrap_pc", fu2.fetch_PC, 32'hFFFF_FFFC);
`ifdef FETCH_ALIGN_CHK_EN
      chk("rst_misalign", 32'(fu.if_misalign), 32'h0);
`endif
      rst = 1'b0;
      #1;
      chk("t1_req0", 32'(fu.imem_req), 32'h1);
      chk("t1_addr0", fu.imem_addr, 32'h0);
      chk("wrap_addr0", fu2.imem_addr, 32'hFFFF_FFFC);
      chk("t1_valid0", 32'(fu.if_valid), 32'h0);
      tick();
      chk("t1_valid1", 32'(fu.if_valid), 32'h1);
      chk("t1_pc4_a", fu.if_PC_plus4, 32'h4);
      chk("t1_instr_a", fu.if_instr, 32'hFFFF_FFFF);
      chk("t1_addr1", fu.imem_addr, 32'h4);
      chk("wrap_pc4", fu2.if_PC_plus4, 32'h0);
      chk("wrap_instr", fu2.if_instr, 32'h3);
      chk("wrap_addr1", fu2.imem_addr, 32'h0);
      tick();
      chk("t1_pc4_b", fu.if_PC_plus4, 32'h8);
      chk("t1_instr_b", fu.if_instr, 32'hFFFF_FFFB);
      chk("t1_addr2", fu.imem_addr, 32'h8);
      tick();
      chk("t1_pc4_c", fu.if_PC_plus4, 32'hC);

      // stall with latency 2: queue fills to 2, req drops, one pop frees a slot
      fu.if_ready = 1'b0;
      lat = 2;
      do_reset();
      repeat (3) tick();
      chk("t2_valid", 32'(fu.if_valid), 32'h1);
      chk("t2_pc4_first", fu.if_PC_plus4, 32'h4);
      chk("t2_addr_b", fu.imem_addr, 32'h4);
      repeat (3) tick();
      chk("t2_full_req", 32'(fu.imem_req), 32'h0);
      chk("t2_full_addr", fu.imem_addr, 32'h8);
      chk("t2_full_head", fu.if_PC_plus4, 32'h4);
      tick();
      chk("t2_still_low", 32'(fu.imem_req), 32'h0);
      fu.if_ready = 1'b1;
      tick();
      fu.if_ready = 1'b0;
      chk("t2_pop_head", fu.if_PC_plus4, 32'h8);
      chk("t2_resume_req", 32'(fu.imem_req), 32'h1);
      chk("t2_resume_addr", fu.imem_addr, 32'h8);
      repeat (3) tick();
      chk("t2_refull_req", 32'(fu.imem_req), 32'h0);
      chk("t2_refull_addr", fu.imem_addr, 32'hC);
      fu.if_ready = 1'b1;
      tick();
      chk("t2_order", fu.if_PC_plus4, 32'hC);

      // redirect while request to 0x8 is pending, ack arrives later
      auto_ack = 1'b0;
      man_ack = 1'b0;
      fu.if_ready = 1'b1;
      do_reset();
      man_ack = 1'b1;
      tick();
      tick();
      man_ack = 1'b0;
      chk("t3_pending_addr", fu.imem_addr, 32'h8);
      fu.redirect = 1'b1;
      fu.next_PC = 32'h0000_0100;
      tick();
      fu.redirect = 1'b0;
      chk("t3_disc_valid", 32'(fu.if_valid), 32'h0);
      chk("t3_disc_addr", fu.imem_addr, 32'h8);
      chk("t3_disc_req", 32'(fu.imem_req), 32'h1);
      tick();
      chk("t3_disc_valid2", 32'(fu.if_valid), 32'h0);
      tick();
      chk("t3_disc_valid3", 32'(fu.if_valid), 32'h0);
      man_ack = 1'b1;
      tick();
      man_ack = 1'b0;
      chk("t3_new_addr", fu.imem_addr, 32'h100);
      chk("t3_new_req", 32'(fu.imem_req), 32'h1);
      chk("t3_drop_valid", 32'(fu.if_valid), 32'h0);
      man_ack = 1'b1;
      tick();
      man_ack = 1'b0;
      chk("t3_first_valid", 32'(fu.if_valid), 32'h1);
      chk("t3_first_pc4", fu.if_PC_plus4, 32'h104);
      chk("t3_first_instr", fu.if_instr, 32'hFFFF_FEFF);

      // redirect and ack in the same cycle
      man_ack = 1'b1;
      fu.redirect = 1'b1;
      fu.next_PC = 32'h0000_0200;
      tick();
      man_ack = 1'b0;
      fu.redirect = 1'b0;
      chk("t4_flush_valid", 32'(fu.if_valid), 32'h0);
      chk("t4_new_addr", fu.imem_addr, 32'h200);
      chk("t4_req", 32'(fu.imem_req), 32'h1);

      // second redirect while discarding overwrites the pending target
      fu.redirect = 1'b1;
      fu.next_PC = 32'h0000_0300;
      tick();
      chk("t5_stale_addr", fu.imem_addr, 32'h200);
      fu.next_PC = R2_PC;
      tick();
      fu.redirect = 1'b0;
      man_ack = 1'b1;
      chk("t5_still_stale", fu.imem_addr, 32'h200);
      tick();
      man_ack = 1'b0;
      chk("t5_target", fu.imem_addr, 32'h400);
      chk("t5_valid", 32'(fu.if_valid), 32'h0);

`ifdef FETCH_ALIGN_CHK_EN
      // misaligned redirect halts until reset
      fu.redirect = 1'b1;
      fu.next_PC = 32'h0000_0102;
      tick();
      fu.redirect = 1'b0;
      man_ack = 1'b1;
      chk("t6_misalign", 32'(fu.if_misalign), 32'h1);
      chk("t6_req", 32'(fu.imem_req), 32'h0);
      chk("t6_valid", 32'(fu.if_valid), 32'h0);
      repeat (3) tick();
      chk("t6_hold_misalign", 32'(fu.if_misalign), 32'h1);
      chk("t6_hold_req", 32'(fu.imem_req), 32'h0);
      chk("t6_hold_valid", 32'(fu.if_valid), 32'h0);
      man_ack = 1'b0;
      rst = 1'b1;
      tick();
      tick();
      chk("t6_rst_misalign", 32'(fu.if_misalign), 32'h0);
      rst = 1'b0;
      #1;
      chk("t6_restart_req", 32'(fu.imem_req), 32'h1);
      chk("t6_restart_addr", fu.imem_addr, 32'h0);
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
